fp_add_special_pipe: RTL and testbench

- Parametrised, pipelined special-case front end for the floating-point adder.
- Classifies both operands (NaN/sNaN, infinity, zero, subnormal) and produces the IEEE-754 add result directly when a special case applies. Otherwise it forwards the operands to the main adder datapath.
- Operates on a valid/ready stream with 2-cycle latency.
- Maintains sticky exception flags and a saturating special-case event counter.

---
 rtl/fp_add_special_pipe.sv | 196 +++++++++++++++++++
 tb/tb_fp_add_special_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_special_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_special_pipe
// Description : Two-stage special-case front end for the FP adder. Resolves
//               NaN/inf/zero sums directly, forwards all other pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_special_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 1,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     spl_case,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [EXP_W+MAN_W:0]     a_fwd,
    output logic [EXP_W+MAN_W:0]     b_fwd,
    input  logic                     clr_flags,
    output logic                     flag_invalid,
    output logic                     flag_nan,
    output logic [CNT_W-1:0]         spl_count
);

    localparam int                 W         = 1 + EXP_W + MAN_W;
    localparam logic               c_ftz     = (FTZ != 0);
    localparam logic [W-1:0]       c_qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);

    // ---------------- input classification ----------------
    logic w_a_exp_max, w_a_exp_zero, w_a_man_zero;
    logic w_b_exp_max, w_b_exp_zero, w_b_man_zero;
    logic [W-1:0] w_a_adj, w_b_adj;

    assign w_a_exp_max  = &a[W-2:MAN_W];
    assign w_a_exp_zero = ~|a[W-2:MAN_W];
    assign w_a_man_zero = ~|a[MAN_W-1:0];
    assign w_b_exp_max  = &b[W-2:MAN_W];
    assign w_b_exp_zero = ~|b[W-2:MAN_W];
    assign w_b_man_zero = ~|b[MAN_W-1:0];

    // Flushed subnormals keep their sign so signed-zero rules still apply
    assign w_a_adj = (c_ftz && w_a_exp_zero) ? {a[W-1], {(W-1){1'b0}}} : a;
    assign w_b_adj = (c_ftz && w_b_exp_zero) ? {b[W-1], {(W-1){1'b0}}} : b;

    // ---------------- flow control ----------------
    logic r_s1_valid, r_s2_valid;
    logic w_s2_load, w_s1_adv, w_out_hs, w_in_hs;

    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_adv  = r_s1_valid & w_s2_load;
    assign in_ready  = ~r_s1_valid | w_s1_adv;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = r_s2_valid & out_ready;

    // ---------------- stage 1 ----------------
    logic [W-1:0] r_s1_a, r_s1_b;
    logic r_a_nan, r_a_snan, r_a_inf, r_a_zero;
    logic r_b_nan, r_b_snan, r_b_inf, r_b_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_a_nan    <= 1'b0;
            r_a_snan   <= 1'b0;
            r_a_inf    <= 1'b0;
            r_a_zero   <= 1'b0;
            r_b_nan    <= 1'b0;
            r_b_snan   <= 1'b0;
            r_b_inf    <= 1'b0;
            r_b_zero   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_hs) begin
                r_s1_a   <= w_a_adj;
                r_s1_b   <= w_b_adj;
                r_a_nan  <= w_a_exp_max & ~w_a_man_zero;
                r_a_snan <= w_a_exp_max & ~w_a_man_zero & ~a[MAN_W-1];
                r_a_inf  <= w_a_exp_max & w_a_man_zero;
                r_a_zero <= w_a_exp_zero & (w_a_man_zero | c_ftz);
                r_b_nan  <= w_b_exp_max & ~w_b_man_zero;
                r_b_snan <= w_b_exp_max & ~w_b_man_zero & ~b[MAN_W-1];
                r_b_inf  <= w_b_exp_max & w_b_man_zero;
                r_b_zero <= w_b_exp_zero & (w_b_man_zero | c_ftz);
            end
        end
    end

    // ---------------- special-case resolution (first match wins) ----------------
    logic         w_spl, w_invalid, w_nan_res;
    logic [W-1:0] w_res;

    always_comb begin
        w_spl     = 1'b1;
        w_res     = '0;
        w_invalid = r_a_snan | r_b_snan;
        w_nan_res = 1'b0;
        if (r_a_nan | r_b_nan) begin
            w_res     = c_qnan;
            w_nan_res = 1'b1;
        end else if (r_a_inf & r_b_inf) begin
            if (r_s1_a[W-1] == r_s1_b[W-1]) begin
                w_res = r_s1_a;
            end else begin
                w_res     = c_qnan;
                w_nan_res = 1'b1;
                w_invalid = 1'b1;
            end
        end else if (r_a_inf) begin
            w_res = r_s1_a;
        end else if (r_b_inf) begin
            w_res = r_s1_b;
        end else if (r_a_zero & r_b_zero) begin
            w_res = {r_s1_a[W-1] & r_s1_b[W-1], {(W-1){1'b0}}};
        end else if (r_a_zero) begin
            w_res = r_s1_b;
        end else if (r_b_zero) begin
            w_res = r_s1_a;
        end else begin
            w_spl = 1'b0;
        end
    end

    // ---------------- stage 2 ----------------
    logic         r_spl, r_s2_invalid, r_s2_nan;
    logic [W-1:0] r_result, r_a_fwd, r_b_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_spl        <= 1'b0;
            r_result     <= '0;
            r_a_fwd      <= '0;
            r_b_fwd      <= '0;
            r_s2_invalid <= 1'b0;
            r_s2_nan     <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_spl        <= w_spl;
                r_result     <= w_res;
                r_a_fwd      <= r_s1_a;
                r_b_fwd      <= r_s1_b;
                r_s2_invalid <= w_invalid;
                r_s2_nan     <= w_nan_res;
            end
        end
    end

    // ---------------- sticky flags and event counter ----------------
    logic             r_flag_invalid, r_flag_nan;
    logic [CNT_W-1:0] r_spl_count;
    logic             w_cnt_inc;

    assign w_cnt_inc = w_out_hs & r_spl;

    // A clear coinciding with an update keeps only the current transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_invalid <= 1'b0;
            r_flag_nan     <= 1'b0;
            r_spl_count    <= '0;
        end else if (clr_flags) begin
            r_flag_invalid <= w_out_hs & r_s2_invalid;
            r_flag_nan     <= w_out_hs & r_s2_nan;
            r_spl_count    <= w_cnt_inc ? c_cnt_one : '0;
        end else begin
            r_flag_invalid <= r_flag_invalid | (w_out_hs & r_s2_invalid);
            r_flag_nan     <= r_flag_nan | (w_out_hs & r_s2_nan);
            if (w_cnt_inc && (r_spl_count != c_cnt_max)) begin
                r_spl_count <= r_spl_count + c_cnt_one;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign spl_case     = r_spl;
    assign result       = r_result;
    assign a_fwd        = r_a_fwd;
    assign b_fwd        = r_b_fwd;
    assign flag_invalid = r_flag_invalid;
    assign flag_nan     = r_flag_nan;
    assign spl_count    = r_spl_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_special_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_special_pipe
// Description : Directed self-checking bench for fp_add_special_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_special_pipe;

    localparam logic [31:0] c_qnan = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clr_flags;
    logic [31:0] a, b;

    logic        in_ready, out_valid, spl_case, flag_invalid, flag_nan;
    logic [31:0] result, a_fwd, b_fwd;
    logic [1:0]  spl_count;

    logic        nf_in_ready, nf_out_valid, nf_spl_case, nf_flag_invalid, nf_flag_nan;
    logic [31:0] nf_result, nf_a_fwd, nf_b_fwd;
    logic [15:0] nf_spl_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_inv, m_nan, m_cnt, m_nf_cnt;

    always #5 clk = ~clk;

    fp_add_special_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .spl_case(spl_case), .result(result), .a_fwd(a_fwd), .b_fwd(b_fwd),
        .clr_flags(clr_flags), .flag_invalid(flag_invalid), .flag_nan(flag_nan),
        .spl_count(spl_count)
    );

    fp_add_special_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(0), .CNT_W(16)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready),
        .a(a), .b(b), .out_valid(nf_out_valid), .out_ready(out_ready),
        .spl_case(nf_spl_case), .result(nf_result), .a_fwd(nf_a_fwd), .b_fwd(nf_b_fwd),
        .clr_flags(clr_flags), .flag_invalid(nf_flag_invalid), .flag_nan(nf_flag_nan),
        .spl_count(nf_spl_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated pair through an empty pipeline with out_ready held high
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic e_spl, input logic [31:0] e_res,
                           input logic [31:0] e_af, input logic [31:0] e_bf,
                           input logic e_inv, input logic nf_spl, input logic clr);
        logic e_nan;
        e_nan = e_spl && (e_res == c_qnan);
        a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ":early_valid"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ":out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ":spl_case"}, {31'b0, spl_case}, {31'b0, e_spl});
        chk({tag, ":result"}, result, e_res);
        chk({tag, ":a_fwd"}, a_fwd, e_af);
        chk({tag, ":b_fwd"}, b_fwd, e_bf);
        chk({tag, ":nf_valid"}, {31'b0, nf_out_valid}, 32'd1);
        chk({tag, ":nf_spl"}, {31'b0, nf_spl_case}, {31'b0, nf_spl});
        chk({tag, ":nf_a_fwd"}, nf_a_fwd, va);
        chk({tag, ":nf_b_fwd"}, nf_b_fwd, vb);
        if (!nf_spl) chk({tag, ":nf_result"}, nf_result, 32'd0);
        clr_flags = clr;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        if (clr) begin
            m_inv = int'(e_inv); m_nan = int'(e_nan);
            m_cnt = int'(e_spl); m_nf_cnt = int'(nf_spl);
        end else begin
            m_inv = m_inv | int'(e_inv);
            m_nan = m_nan | int'(e_nan);
            if (e_spl && m_cnt < 3) m_cnt++;
            if (nf_spl) m_nf_cnt++;
        end
        chk({tag, ":drained"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ":flag_invalid"}, {31'b0, flag_invalid}, 32'(m_inv));
        chk({tag, ":flag_nan"}, {31'b0, flag_nan}, 32'(m_nan));
        chk({tag, ":spl_count"}, {30'b0, spl_count}, 32'(m_cnt));
        chk({tag, ":nf_flag_invalid"}, {31'b0, nf_flag_invalid}, 32'(m_inv));
        chk({tag, ":nf_spl_count"}, {16'b0, nf_spl_count}, 32'(m_nf_cnt));
    endtask

    // Stream operands: even index non-special, odd index adds +0 (special, result = a)
    function automatic logic [31:0] st_a(input int i);
        return (i % 2 == 0) ? 32'h3F800000 + 32'(i) : 32'h40400000 + 32'(i);
    endfunction
    function automatic logic [31:0] st_b(input int i);
        return (i % 2 == 0) ? 32'h40000000 : 32'h00000000;
    endfunction

    initial begin
        int          sent, got, inflight;
        logic        hs_in, hs_out, stall_pending;
        logic [31:0] stall_af, stall_res;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
        a = '0; b = '0;
        m_inv = 0; m_nan = 0; m_cnt = 0; m_nf_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst:out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst:in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst:nf_in_ready", {31'b0, nf_in_ready}, 32'd1);
        chk("rst:spl_case", {31'b0, spl_case}, 32'd0);
        chk("rst:result", result, 32'd0);
        chk("rst:a_fwd", a_fwd, 32'd0);
        chk("rst:flags", {30'b0, flag_invalid, flag_nan}, 32'd0);
        chk("rst:spl_count", {30'b0, spl_count}, 32'd0);

        run_vec("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1, c_qnan, 32'h7F800000, 32'hFF800000, 1, 1, 0);
        run_vec("neg_inf_plus_one", 32'hFF800000, 32'h3F800000, 1, 32'hFF800000, 32'hFF800000, 32'h3F800000, 0, 1, 0);
        run_vec("snan_in", 32'h7F800001, 32'h3F800000, 1, c_qnan, 32'h7F800001, 32'h3F800000, 1, 1, 0);
        run_vec("neg0_neg0", 32'h80000000, 32'h80000000, 1, 32'h80000000, 32'h80000000, 32'h80000000, 0, 1, 0);
        run_vec("neg0_pos0", 32'h80000000, 32'h00000000, 1, 32'h00000000, 32'h80000000, 32'h00000000, 0, 1, 0);
        run_vec("ftz_subn", 32'h00000001, 32'h40000000, 1, 32'h40000000, 32'h00000000, 32'h40000000, 0, 0, 0);
        run_vec("normal", 32'h3F800000, 32'h40000000, 0, 32'h00000000, 32'h3F800000, 32'h40000000, 0, 0, 0);
        run_vec("inf_inf_same", 32'h7F800000, 32'h7F800000, 1, 32'h7F800000, 32'h7F800000, 32'h7F800000, 0, 1, 0);
        run_vec("qnan_over_inf", 32'h7FC00001, 32'hFF800000, 1, c_qnan, 32'h7FC00001, 32'hFF800000, 0, 1, 0);
        run_vec("zero_plus_ninf", 32'h00000000, 32'hFF800000, 1, 32'hFF800000, 32'h00000000, 32'hFF800000, 0, 1, 0);
        run_vec("ftz_neg_subn", 32'h80000001, 32'h80000000, 1, 32'h80000000, 32'h80000000, 32'h80000000, 0, 1, 0);
        run_vec("clr_with_spl", 32'hFF800000, 32'h3F800000, 1, 32'hFF800000, 32'hFF800000, 32'h3F800000, 0, 1, 1);
        run_vec("clr_with_snan", 32'h7F800001, 32'h00000000, 1, c_qnan, 32'h7F800001, 32'h00000000, 1, 1, 1);

        // Clear with no handshake in flight
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_inv = 0; m_nan = 0; m_cnt = 0; m_nf_cnt = 0;
        chk("clr_idle:flags", {30'b0, flag_invalid, flag_nan}, 32'd0);
        chk("clr_idle:spl_count", {30'b0, spl_count}, 32'd0);
        chk("clr_idle:nf_spl_count", {16'b0, nf_spl_count}, 32'd0);

        // Streaming with out_ready toggling every cycle
        sent = 0; got = 0; inflight = 0; stall_pending = 1'b0;
        stall_af = '0; stall_res = '0;
        out_ready = 1'b1; in_valid = 1'b1; a = st_a(0); b = st_b(0);
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            chk("stream:in_ready", {31'b0, in_ready}, {31'b0, !(inflight == 2 && !out_ready)});
            if (stall_pending) begin
                chk("stream:hold_valid", {31'b0, out_valid}, 32'd1);
                chk("stream:hold_a_fwd", a_fwd, stall_af);
                chk("stream:hold_result", result, stall_res);
                stall_pending = 1'b0;
            end
            if (hs_out) begin
                chk("stream:a_fwd", a_fwd, st_a(got));
                chk("stream:b_fwd", b_fwd, st_b(got));
                chk("stream:spl_case", {31'b0, spl_case}, {31'b0, got % 2 == 1});
                chk("stream:result", result, (got % 2 == 1) ? st_a(got) : 32'd0);
                got++;
            end else if (out_valid) begin
                stall_pending = 1'b1;
                stall_af = a_fwd;
                stall_res = result;
            end
            @(posedge clk); #1;
            inflight = inflight + int'(hs_in) - int'(hs_out);
            if (hs_in) sent++;
            if (sent < 10) begin
                in_valid = 1'b1; a = st_a(sent); b = st_b(sent);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ~out_ready;
        end
        chk("stream:count", 32'(got), 32'd10);
        chk("stream:sent", 32'(sent), 32'd10);
        @(posedge clk); #1;
        chk("stream:spl_count_sat", {30'b0, spl_count}, 32'd3);
        chk("stream:nf_spl_count", {16'b0, nf_spl_count}, 32'd5);
        chk("stream:flags", {30'b0, flag_invalid, flag_nan}, 32'd0);

        // Reset while two pairs are in flight
        out_ready = 1'b1; in_valid = 1'b1; a = 32'h7F800000; b = 32'hFF800000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst:pre_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst:out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst:spl_count", {30'b0, spl_count}, 32'd0);
        chk("midrst:flags", {30'b0, flag_invalid, flag_nan}, 32'd0);
        chk("midrst:result", result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst:discarded", {31'b0, out_valid}, 32'd0);
        end
        chk("midrst:flags_after", {30'b0, flag_invalid, flag_nan}, 32'd0);
        chk("midrst:count_after", {30'b0, spl_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
